// File: rtl/stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stage_sequencer
// Purpose  : One-hot multicycle stage controller with skipping, stalls,
//            condition-fail early retire, flush and retire/stall counters.
// Revision : 1.0  initial release
// ============================================================================
module stage_sequencer #(
    parameter  int NUM_STAGES   = 5,
    parameter  int DECODE_STAGE = 1,
    parameter  int COND_STAGE   = 2,
    parameter  int CNT_WIDTH    = 16,
    localparam int STAGE_W      = $clog2(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  run,
    input  logic [NUM_STAGES-1:0] skip_mask,
    input  logic                  stall,
    input  logic                  cond_fail,
    input  logic                  flush,
    input  logic                  clr_counts,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic                  stage_adv,
    output logic [STAGE_W-1:0]    stage_idx,
    output logic                  busy,
    output logic                  retire,
    output logic [CNT_WIDTH-1:0]  retire_count,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    localparam logic [STAGE_W-1:0]    c_DECODE   = STAGE_W'(DECODE_STAGE);
    localparam logic [STAGE_W-1:0]    c_COND     = STAGE_W'(COND_STAGE);
    localparam logic [NUM_STAGES-1:0] c_LOW_BITS = NUM_STAGES'((1 << (DECODE_STAGE + 1)) - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [STAGE_W-1:0]    r_stage;
    logic [STAGE_W-1:0]    w_nextStage;
    logic [NUM_STAGES-1:0] r_mask;
    logic [NUM_STAGES-1:0] w_nextMask;
    logic [CNT_WIDTH-1:0]  r_retireCount;
    logic [CNT_WIDTH-1:0]  r_stallCount;

    logic                  w_busy;
    logic                  w_adv;
    logic                  w_atDecode;
    logic                  w_retire;
    logic                  w_found;
    logic [NUM_STAGES-1:0] w_decMask;
    logic [NUM_STAGES-1:0] w_effMask;
    logic [NUM_STAGES-1:0] w_above;
    logic [NUM_STAGES-1:0] w_cand;
    logic [NUM_STAGES-1:0] w_low;
    logic [STAGE_W-1:0]    w_lowest;

    // Next-stage search: the decode stage uses the incoming mask directly so
    // the stage right after decode already honours it.
    always_comb begin
        w_busy     = (r_state == BUSY);
        w_adv      = w_busy & ~stall & ~flush;
        w_atDecode = (r_stage == c_DECODE);
        w_decMask  = skip_mask & ~c_LOW_BITS;
        w_effMask  = w_atDecode ? w_decMask : r_mask;
        w_above    = ({NUM_STAGES{1'b1}} << r_stage) << 1;
        w_cand     = ~w_effMask & w_above;
        w_low      = w_cand & (~w_cand + NUM_STAGES'(1));
        w_found    = |w_cand;
        w_lowest   = '0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            if (w_low == (NUM_STAGES'(1) << j)) begin
                w_lowest = STAGE_W'(j);
            end
        end
        w_retire = w_adv & (((r_stage == c_COND) & cond_fail) | ~w_found);
    end

    always_comb begin
        w_nextState = r_state;
        w_nextStage = r_stage;
        w_nextMask  = r_mask;
        case (r_state)
            IDLE: begin
                if (run) begin
                    w_nextState = BUSY;
                    w_nextStage = '0;
                    w_nextMask  = '0;
                end
            end
            BUSY: begin
                if (flush || w_retire) begin
                    w_nextState = run ? BUSY : IDLE;
                    w_nextStage = '0;
                    w_nextMask  = '0;
                end else if (!stall) begin
                    w_nextStage = w_lowest;
                    if (w_atDecode) begin
                        w_nextMask = w_decMask;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextStage = '0;
                w_nextMask  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            r_state <= IDLE;
            r_stage <= '0;
            r_mask  <= '0;
        end else begin
            r_state <= w_nextState;
            r_stage <= w_nextStage;
            r_mask  <= w_nextMask;
        end
    end

    // Clearing wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (nreset || clr_counts) begin
            r_retireCount <= '0;
            r_stallCount  <= '0;
        end else begin
            if (w_retire) begin
                r_retireCount <= r_retireCount + CNT_WIDTH'(1);
            end
            if (w_busy && stall && !flush) begin
                r_stallCount <= r_stallCount + CNT_WIDTH'(1);
            end
        end
    end

    assign stage_en     = w_busy ? (NUM_STAGES'(1) << r_stage) : '0;
    assign stage_idx    = w_busy ? r_stage : '0;
    assign stage_adv    = w_adv;
    assign busy         = w_busy;
    assign retire       = w_retire;
    assign retire_count = r_retireCount;
    assign stall_count  = r_stallCount;

endmodule
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_sequencer
// Purpose  : Directed bench for stage_sequencer with a stage-list model.
// Revision : 1.0  initial release
// ============================================================================
module tb_stage_sequencer;

    localparam int NS  = 5;
    localparam int DEC = 1;
    localparam int CND = 2;

    logic          clk = 1'b0;
    logic          nreset, run, stall, cond_fail, flush, clr_counts;
    logic [NS-1:0] skip_mask;

    logic [NS-1:0] stage_en;
    logic          stage_adv, busy, retire;
    logic [2:0]    stage_idx;
    logic [15:0]   retire_count, stall_count;

    logic [NS-1:0] wEn;
    logic          wAdv, wBusy, wRet;
    logic [2:0]    wIdx;
    logic [3:0]    wRetCnt, wStlCnt;

    stage_sequencer #(.NUM_STAGES(NS), .DECODE_STAGE(DEC), .COND_STAGE(CND), .CNT_WIDTH(16)) dut (
        .clk(clk), .nreset(nreset), .run(run), .skip_mask(skip_mask), .stall(stall),
        .cond_fail(cond_fail), .flush(flush), .clr_counts(clr_counts),
        .stage_en(stage_en), .stage_adv(stage_adv), .stage_idx(stage_idx), .busy(busy),
        .retire(retire), .retire_count(retire_count), .stall_count(stall_count)
    );

    // Narrow-counter copy so counter wrap is reachable in a short run.
    stage_sequencer #(.NUM_STAGES(NS), .DECODE_STAGE(DEC), .COND_STAGE(CND), .CNT_WIDTH(4)) dutW (
        .clk(clk), .nreset(nreset), .run(run), .skip_mask(skip_mask), .stall(stall),
        .cond_fail(cond_fail), .flush(flush), .clr_counts(clr_counts),
        .stage_en(wEn), .stage_adv(wAdv), .stage_idx(wIdx), .busy(wBusy),
        .retire(wRet), .retire_count(wRetCnt), .stall_count(wStlCnt)
    );

    always #5 clk = ~clk;

    int nComp = 0;
    int nFail = 0;
    bit checkEn = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nComp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an instruction is the list of stages it still has to visit.
    bit mBusy;
    int q[$];
    int mRet, mStl;

    function automatic bit modelRetire();
        int cnt;
        if (!(mBusy && !stall && !flush)) return 1'b0;
        if (q[0] == CND && cond_fail) return 1'b1;
        cnt = 0;
        for (int k = 1; k < q.size(); k++)
            if (!(q[0] == DEC && skip_mask[q[k]])) cnt++;
        return (cnt == 0);
    endfunction

    function automatic void startInstr();
        q = {};
        for (int s = 0; s < NS; s++) q.push_back(s);
        mBusy = 1'b1;
    endfunction

    function automatic void advance();
        int tmp[$];
        int cur;
        cur = q[0];
        for (int k = 1; k < q.size(); k++)
            if (!(cur == DEC && skip_mask[q[k]])) tmp.push_back(q[k]);
        q = tmp;
    endfunction

    always @(posedge clk) begin : p_model
        bit r, s;
        r = modelRetire();
        s = mBusy && stall && !flush;
        if (nreset) begin
            mBusy = 1'b0; q = {}; mRet = 0; mStl = 0;
        end else begin
            if (clr_counts) begin
                mRet = 0; mStl = 0;
            end else begin
                if (r) mRet = (mRet + 1) & 32'hFFFF;
                if (s) mStl = (mStl + 1) & 32'hFFFF;
            end
            if (!mBusy) begin
                if (run) startInstr();
            end else if (flush || r) begin
                if (run) startInstr();
                else begin mBusy = 1'b0; q = {}; end
            end else if (!stall) begin
                advance();
            end
        end
    end

    always @(negedge clk) begin : p_cmp
        logic [NS-1:0] eEn;
        logic [2:0]    eIdx;
        bit            eAdv, eRet;
        if (checkEn) begin
            eEn  = mBusy ? NS'(1 << q[0]) : '0;
            eIdx = mBusy ? 3'(q[0]) : 3'd0;
            eAdv = mBusy && !stall && !flush;
            eRet = modelRetire();
            chk("stage_en", 32'(stage_en), 32'(eEn));
            chk("stage_idx", 32'(stage_idx), 32'(eIdx));
            chk("busy", 32'(busy), 32'(mBusy));
            chk("stage_adv", 32'(stage_adv), 32'(eAdv));
            chk("retire", 32'(retire), 32'(eRet));
            chk("retire_count", 32'(retire_count), 32'(mRet & 16'hFFFF));
            chk("stall_count", 32'(stall_count), 32'(mStl & 16'hFFFF));
            chk("w_stage_en", 32'(wEn), 32'(eEn));
            chk("w_stage_idx", 32'(wIdx), 32'(eIdx));
            chk("w_busy", 32'(wBusy), 32'(mBusy));
            chk("w_stage_adv", 32'(wAdv), 32'(eAdv));
            chk("w_retire", 32'(wRet), 32'(eRet));
            chk("w_retire_count", 32'(wRetCnt), 32'(mRet & 15));
            chk("w_stall_count", 32'(wStlCnt), 32'(mStl & 15));
        end
    end

    task automatic waitCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic nextCycle();
        waitCycle();
        stall = 1'b0;
        cond_fail = 1'b0;
    endtask

    task automatic launch();
        run = 1'b1;
        waitCycle();
    endtask

    // Drives one instruction from its STAGE_0 cycle up to its retire cycle;
    // seq is the visited stage indices as decimal digits.
    task automatic runInstr(input logic [NS-1:0] mask, input int stallStg, input int stallN,
                            input int condStg, input bit runAfter, output int seq, output int lat);
        int done;
        done = 0; seq = 0; lat = 0;
        skip_mask = mask;
        run = runAfter;
        for (int c = 0; c < 30; c++) begin
            stall = (int'(stage_idx) == stallStg) && (done < stallN);
            if (stall) done++;
            cond_fail = (int'(stage_idx) == condStg);
            seq = seq * 10 + int'(stage_idx);
            lat++;
            #1;
            if (retire) return;
            waitCycle();
        end
        chk("instr_timeout", 32'd1, 32'd0);
    endtask

    initial begin : p_watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, nComp=%0d", nComp);
        $fatal(1, "watchdog expired");
    end

    initial begin : p_stim
        int seq, lat;
        nreset = 1'b1; run = 1'b0; stall = 1'b0; cond_fail = 1'b0;
        flush = 1'b0; clr_counts = 1'b0; skip_mask = '0;
        waitCycle();
        checkEn = 1'b1;
        waitCycle();
        chk("reset_en", 32'(stage_en), 32'd0);
        chk("reset_idx", 32'(stage_idx), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_retire", 32'(retire), 32'd0);
        chk("reset_retcnt", 32'(retire_count), 32'd0);
        chk("reset_stlcnt", 32'(stall_count), 32'd0);

        // Free-running full instructions.
        nreset = 1'b0;
        run = 1'b1;
        waitCycle();
        for (int k = 0; k < 15; k++) begin
            chk("loop_en", 32'(stage_en), 32'(1 << (k % 5)));
            chk("loop_retire", 32'(retire), 32'((k % 5) == 4));
            waitCycle();
        end
        chk("loop_retcnt3", 32'(retire_count), 32'd3);

        // run dropped in stage 1: instruction still completes, then idle.
        waitCycle();
        run = 1'b0;
        waitCycle(); waitCycle(); waitCycle();
        chk("runlow_s4_en", 32'(stage_en), 32'h10);
        chk("runlow_retire", 32'(retire), 32'd1);
        waitCycle();
        chk("runlow_idle_en", 32'(stage_en), 32'd0);
        chk("runlow_idle_busy", 32'(busy), 32'd0);
        chk("runlow_retcnt", 32'(retire_count), 32'd4);

        launch(); runInstr(5'b01000, -1, 0, -1, 1'b0, seq, lat);
        chk("skip3_seq", seq, 124); chk("skip3_lat", lat, 4);
        nextCycle();
        launch(); runInstr(5'b11100, -1, 0, -1, 1'b0, seq, lat);
        chk("skip234_seq", seq, 1); chk("skip234_lat", lat, 2);
        nextCycle();
        launch(); runInstr(5'b00011, -1, 0, -1, 1'b0, seq, lat);
        chk("skiplow_seq", seq, 1234); chk("skiplow_lat", lat, 5);
        nextCycle();
        chk("skip_retcnt", 32'(retire_count), 32'd7);

        // Three stall cycles in stage 3, then counter clear.
        launch(); runInstr(5'b00000, 3, 3, -1, 1'b0, seq, lat);
        chk("stall_seq", seq, 1233334); chk("stall_lat", lat, 8);
        chk("stall_cnt", 32'(stall_count), 32'd3);
        nextCycle();
        chk("stall_retcnt", 32'(retire_count), 32'd8);
        clr_counts = 1'b1;
        waitCycle();
        clr_counts = 1'b0;
        chk("clr_retcnt", 32'(retire_count), 32'd0);
        chk("clr_stlcnt", 32'(stall_count), 32'd0);

        // Condition fail honoured in stage 2, ignored in stage 3.
        launch(); runInstr(5'b00000, -1, 0, 2, 1'b1, seq, lat);
        chk("cond2_seq", seq, 12); chk("cond2_lat", lat, 3);
        nextCycle();
        chk("cond2_next_en", 32'(stage_en), 32'd1);
        chk("cond2_retcnt", 32'(retire_count), 32'd1);
        runInstr(5'b00000, -1, 0, 3, 1'b0, seq, lat);
        chk("cond3_lat", lat, 5);
        nextCycle();

        // Flush beats stall and cond_fail.
        launch();
        skip_mask = '0;
        waitCycle(); waitCycle();
        flush = 1'b1; stall = 1'b1; cond_fail = 1'b1;
        #1;
        chk("flush_retire", 32'(retire), 32'd0);
        chk("flush_adv", 32'(stage_adv), 32'd0);
        waitCycle();
        flush = 1'b0; stall = 1'b0; cond_fail = 1'b0;
        chk("flush_next_en", 32'(stage_en), 32'd1);
        chk("flush_retcnt", 32'(retire_count), 32'd2);
        chk("flush_stlcnt", 32'(stall_count), 32'd0);
        runInstr(5'b00000, -1, 0, -1, 1'b0, seq, lat);
        chk("flush_after_lat", lat, 5);
        nextCycle();

        // Reset in the middle of an instruction.
        launch();
        waitCycle(); waitCycle(); waitCycle();
        nreset = 1'b1;
        #1;
        chk("rst_mid_s3", 32'(stage_en), 32'h08);
        waitCycle();
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_retcnt", 32'(retire_count), 32'd0);
        nreset = 1'b0; run = 1'b0;
        waitCycle();

        // Wrap of the 4-bit counter copy.
        launch();
        for (int i = 0; i < 16; i++) begin
            runInstr(5'b11100, -1, 0, -1, (i < 15), seq, lat);
            chk("wrap_lat", lat, 2);
            nextCycle();
            if (i == 14) chk("wrap_at_max", 32'(wRetCnt), 32'hF);
        end
        chk("wrap_zero", 32'(wRetCnt), 32'd0);
        chk("wrap_main_cnt", 32'(retire_count), 32'd16);
        waitCycle();

        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
        $finish;
    end

endmodule
`default_nettype wire
